// File: rtl/sum_nibble_seq_if.sv
// Handshake and operand/result bundle for the nibble-serial adder/subtractor.
// WIDTH must match the WIDTH of the sum_nibble_seq instance it connects to.
interface sum_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, s, cout, ovf, zero
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, s, cout, ovf, zero
    );
endinterface

// File: rtl/sum_nibble_seq.sv
// Nibble-serial WIDTH-bit adder/subtractor: one CHUNK-bit carry chain, LSB chunk first.
// Optional SUMSEQ_SAT_EN clamps an overflowing result to signed saturation.
module sum_nibble_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    sum_nibble_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             last_ovf;
    logic [WIDTH-1:0] final_s;

    // Operands shift right each cycle so the active chunk is always at bit 0;
    // sum chunks enter the result from the top and land in place after N shifts.
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
        msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last_ovf  = msb_cin ^ chunk_sum[CHUNK];
        final_s   = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        k_d     = k_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.cin ^ bus.sub;
                    k_d     = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = chunk_sum[CHUNK];
                res_d = final_s;
                k_d   = k_q + 1'b1;
                if (k_q == KW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = last_ovf;
`ifdef SUMSEQ_SAT_EN
                    // Both MSBs clear means the true result is positive.
                    if (last_ovf)
                        s_d = (!a_q[CHUNK-1] && !b_q[CHUNK-1]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                               : {1'b1, {(WIDTH-1){1'b0}}};
                    else
                        s_d = final_s;
`else
                    s_d = final_s;
`endif
                    zero_d = (s_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            k_q     <= k_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_sum_nibble_seq.sv
// Self-checking bench for sum_nibble_seq: arithmetic model plus directed literal checks.
// Build with +define+SUMSEQ_SAT_EN to check the saturating variant.
module tb_sum_nibble_seq;
    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_nibble_seq_if #(.WIDTH(W)) bus ();

    sum_nibble_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one operation from plain integer arithmetic.
    function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub,
                                     output logic [W-1:0] s, output logic cout,
                                     output logic ovf, output logic zero);
        logic [W:0] full;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            s    = full[W-1:0];
            cout = full[W];
            ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s    = a - b - W'(cin);
            cout = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
            ovf  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
`ifdef SUMSEQ_SAT_EN
        if (ovf) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        zero = (s == '0);
    endfunction

    // Model state: remaining RUN cycles and the visible output registers.
    logic         m_valid = 1'b0;
    int           m_rem   = 0;
    logic [W-1:0] m_a, m_b, m_s;
    logic         m_cin, m_sub, m_cout, m_ovf, m_zero, m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_rem   = 0;
            m_s     = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_zero  = 1'b0;
            m_done  = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    model_op(m_a, m_b, m_cin, m_sub, m_s, m_cout, m_ovf, m_zero);
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                m_a   = bus.a;
                m_b   = bus.b;
                m_cin = bus.cin;
                m_sub = bus.sub;
                m_rem = N;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("cycle_model",
                  32'({bus.ready, bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.s}),
                  32'({m_rem == 0, m_rem != 0, m_done, m_cout, m_ovf, m_zero, m_s}));
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
        bus.sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int busy_cycles);
        int cycles = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        if (bus.done !== 1'b1) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_result(input string name, input logic [W-1:0] s,
                                input logic cout, input logic ovf, input logic zero);
        check(name, 32'({bus.cout, bus.ovf, bus.zero, bus.s}), 32'({cout, ovf, zero, s}));
    endtask

    initial begin
        int bc;
        int done_seen;

        // Reset asserted together with start: reset must win.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state",
              32'({bus.ready, bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.s}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(bc);
        check_result("add_basic", 16'h5555, 1'b0, 1'b0, 1'b0);
        check("add_busy_cycles", 32'(bc), 32'(4));
        check("add_ready_in_done", 32'(bus.ready), 32'(1));
        @(negedge clk);
        check("add_done_width", 32'(bus.done), 32'(0));

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(bc);
        check_result("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        start_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        wait_done(bc);
`ifdef SUMSEQ_SAT_EN
        check_result("sub_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        check_result("sub_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge clk);

        start_op(16'h0005, 16'h0005, 1'b0, 1'b1);
        wait_done(bc);
        check_result("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back from the done cycle: borrow-in and carry-in variants.
        start_op(16'h0010, 16'h0001, 1'b1, 1'b1);
        wait_done(bc);
        check_result("sub_borrow_in", 16'h000E, 1'b1, 1'b0, 1'b0);

        start_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        wait_done(bc);
`ifdef SUMSEQ_SAT_EN
        check_result("add_cin_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        check_result("add_cin_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
`endif

        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(bc);
`ifdef SUMSEQ_SAT_EN
        check_result("sub_neg_ovf", 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        check_result("sub_neg_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            wait_done(bc);
        end
        @(negedge clk);

        // start held through busy with new operands: must be ignored.
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.a = 16'h00FF;
        bus.b = 16'h0001;
        wait_done(bc);
        check_result("ignored_start", 16'h0002, 1'b0, 1'b0, 1'b0);
        check("ready_in_done", 32'(bus.ready), 32'(1));
        // start still high in the done cycle: accepted with no bubble.
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'(1));
        wait_done(bc);
        check_result("back_to_back", 16'h0100, 1'b0, 1'b0, 1'b0);
        check("b2b_busy_cycles", 32'(bc), 32'(4));
        @(negedge clk);

        // Abort: rst sampled at the second RUN edge.
        start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'({bus.ready, bus.busy, bus.done, bus.s}),
              32'({1'b1, 1'b0, 1'b0, 16'h0000}));
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sum_nibble_seq.md
Name: sum_nibble_seq

Overview:
- Parametrised, nibble-serial adder/subtractor. Successor to the 4-bit combinational nibble adder.
- Processes a WIDTH-bit add or subtract CHUNK bits per clock, LSB chunk first, reusing one CHUNK-bit carry chain.
- Uses a start/ready/done handshake and reports carry, signed overflow and zero flags.
- Sits in the datapath ALU as the low-area arithmetic unit for wide operands.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- a  in  WIDTH  operand A; sampled only at acceptance.
- b  in  WIDTH  operand B; sampled only at acceptance.
- cin  in  1  carry-in (add) / borrow-in (sub); sampled at acceptance.
- sub  in  1  0 = a+b+cin; 1 = a-b-cin; sampled at acceptance.
- ready  out  1  idle, can accept start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, results just updated.
- s  out  WIDTH  result, registered.
- cout  out  1  add: carry out; sub: 1 = no borrow (a >= b+cin unsigned).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; ready=1; busy=0; done=0; s=0; cout=0; ovf=0; zero=0; internal chunk counter and shift registers cleared. Reset wins over start in the same cycle.
- States: IDLE, RUN.
- IDLE: ready=1, busy=0.
  - On acceptance, latch A=a and B'=(sub ? ~b : b), and set chunk carry c=cin^sub. So sub computes a + ~b + (1-cin).
  - Counter k=0; go to RUN.
- RUN: ready=0, busy=1.
  - Each edge: add chunk k of A and B' plus c, giving CHUNK sum bits and a new c; store into chunk k of the internal result; k=k+1.
  - The signed overflow term for the top chunk is taken as carry-into-MSB xor carry-out-of-MSB.
- Completion: the edge that processes chunk N-1 loads s, cout=c, ovf and zero (computed from the final s) into output registers.
  - Same edge: done=1 for exactly one cycle, ready=1, busy=0, back to IDLE.
  - Latency: start accepted at edge E0, done high and results valid after edge E0+N (N=4 at defaults).
- s/cout/ovf/zero hold their previous values throughout RUN and until the next completion; they never show partial results.
- start while busy: ignored, and latched operands are unaffected.
- start during the done cycle (ready=1): accepted, back-to-back with no bubble.
- Operand inputs may change freely after acceptance.
- rst during RUN: operation aborted, reset values applied, no done pulse.
- CHUNK==WIDTH is legal (N=1, single-cycle RUN).

Optional Feature:
- Macro: SUMSEQ_SAT_EN.
- Defined: when ovf=1 at completion, s is clamped to signed saturation.
  - Positive overflow (A and B' MSBs both 0) gives 0111..1.
  - Negative overflow gives 1000..0.
  - ovf still reports 1. cout is unchanged. zero is evaluated on the clamped s.
- Not defined: s wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan (WIDTH=16, CHUNK=4):
- Add 0x1234+0x4321, cin=0 -> after E0+4: s=0x5555, cout=0, ovf=0, zero=0, done high exactly 1 cycle, busy high for 4 cycles.
- Add 0xFFFF+0x0001, cin=0 -> s=0x0000, cout=1, ovf=0, zero=1.
- Sub 0x7FFF-0xFFFF, cin=0 -> without macro: s=0x8000, ovf=1, cout=0. With SUMSEQ_SAT_EN: s=0x7FFF, ovf=1.
- Sub 0x0005-0x0005, cin=0 -> s=0x0000, zero=1, cout=1, ovf=0.
- start with 0x0001+0x0001 accepted; start with 0x00FF+0x0001 held during busy -> ignored, first result s=0x0002.
  - Then start in the done cycle with 0x00FF+0x0001 -> accepted, s=0x0100 after 4 more edges.
- rst=1 at the 2nd RUN edge -> next cycle ready=1, busy=0, s=0, no done pulse ever appears for the aborted operation.
